// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce/strobe input conditioner.
package debounce_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } dbs_state_t;

  function automatic int cnt_width(input int stable);
    return $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchroniser for a single asynchronous bit; resets to 0.
module bit_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic io_in,
  output logic io_out
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= io_in;
      s2_q <= s1_q;
    end
  end

  assign io_out = s2_q;

endmodule

// File: rtl/debounce_strobe.sv
// Debounces one raw bit and emits the accepted level with a one-cycle enable
// strobe for a downstream enable-gated flop; counts aborted transitions.
module debounce_strobe
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_raw,
  output logic                io_D,
  output logic                io_EN,
  output logic                io_busy,
  output logic [GLITCH_W-1:0] io_glitches
);

  localparam int          CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic                s;
  dbs_state_t          state_q;
  logic [CW-1:0]       cnt_q;
  logic                d_q, en_q;
  logic [GLITCH_W-1:0] glitch_q;

  bit_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .io_in (io_raw),
    .io_out(s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      d_q      <= 1'b0;
      en_q     <= 1'b0;
      glitch_q <= '0;
    end else if (s != d_q) begin
      if (cnt_q == CNT_LAST && !en_q) begin
        d_q     <= s;
        en_q    <= 1'b1;
        cnt_q   <= '0;
        state_q <= IDLE;
      end else if (cnt_q == CNT_LAST) begin
        // Only reachable with a single-cycle window: defer one cycle so the
        // strobe never stays high on back-to-back edges.
        en_q    <= 1'b0;
      end else begin
        cnt_q   <= cnt_q + 1'b1;
        state_q <= QUAL;
        en_q    <= 1'b0;
      end
    end else begin
      en_q <= 1'b0;
      if (state_q == QUAL) begin
        cnt_q   <= '0;
        state_q <= IDLE;
        if (glitch_q != '1) glitch_q <= glitch_q + 1'b1;
      end
    end
  end

  assign io_D        = d_q;
  assign io_EN       = en_q;
  assign io_busy     = (state_q == QUAL);
  assign io_glitches = glitch_q;

endmodule

// File: tb/tb_debounce_strobe.sv
// Directed bench for debounce_strobe: expected strobes are queued by the
// stimulus and checked by per-instance monitors when io_EN fires.
module tb_debounce_strobe;

  typedef struct {
    int at;
    int d;
    int gl;
  } exp_t;

  logic clk, rst;
  logic raw_a, raw_b, raw_c;
  logic d_a, en_a, busy_a;
  logic d_b, en_b, busy_b;
  logic d_c, en_c, busy_c;
  logic [7:0] gl_a, gl_c;
  logic [1:0] gl_b;

  int   edge_n = 0;
  int   total = 0;
  int   bad = 0;
  exp_t qa[$];
  exp_t qc[$];
  logic prev_en_a = 1'b0;
  logic prev_en_c = 1'b0;

  debounce_strobe #(.STABLE_CYCLES(4), .GLITCH_W(8)) dut_a (
    .clk(clk), .reset(rst), .io_raw(raw_a), .io_D(d_a), .io_EN(en_a),
    .io_busy(busy_a), .io_glitches(gl_a));

  debounce_strobe #(.STABLE_CYCLES(4), .GLITCH_W(2)) dut_b (
    .clk(clk), .reset(rst), .io_raw(raw_b), .io_D(d_b), .io_EN(en_b),
    .io_busy(busy_b), .io_glitches(gl_b));

  debounce_strobe #(.STABLE_CYCLES(1), .GLITCH_W(8)) dut_c (
    .clk(clk), .reset(rst), .io_raw(raw_c), .io_D(d_c), .io_EN(en_c),
    .io_busy(busy_c), .io_glitches(gl_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edge_n == k when sampled on the falling edge following rising edge k
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", nm, act, exp, edge_n);
    end
  endfunction

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (en_a === 1'b1) begin
      chk("a_en_not_back_to_back", prev_en_a, 0);
      if (qa.size() == 0) chk("a_unexpected_en", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_en_edge", edge_n, e.at);
        chk("a_en_d", d_a, e.d);
        chk("a_en_glitches", gl_a, e.gl);
      end
    end
    prev_en_a = en_a;
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (en_c === 1'b1) begin
      chk("c_en_not_back_to_back", prev_en_c, 0);
      if (qc.size() == 0) chk("c_unexpected_en", 1, 0);
      else begin
        e = qc.pop_front();
        chk("c_en_edge", edge_n, e.at);
        chk("c_en_d", d_c, e.d);
        chk("c_en_glitches", gl_c, e.gl);
      end
    end
    prev_en_c = en_c;
  end

  always @(negedge clk) if (en_b === 1'b1) chk("b_unexpected_en", 1, 0);

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    rst = 1'b1; raw_a = 1'b0; raw_b = 1'b0; raw_c = 1'b0;
    tick(3);
    chk("rst_d", d_a, 0);
    chk("rst_en", en_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_glitches", gl_a, 0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle_en", en_a, 0);
      chk("idle_busy", busy_a, 0);
    end
    chk("idle_d", d_a, 0);
    chk("idle_glitches", gl_a, 0);

    // clean step: raw seen at edge k+1, accepted at edge k+6
    k = edge_n;
    raw_a = 1'b1;
    qa.push_back('{k + 6, 1, 0});
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      chk("step_busy", busy_a, (i >= 3 && i <= 5) ? 1 : 0);
    end
    chk("step_d", d_a, 1);

    rst = 1'b1; raw_a = 1'b0;
    tick(1);
    rst = 1'b0;
    chk("rst_clears_d", d_a, 0);
    tick(4);

    // bounce: 1 for 2 cycles, 0 for 1, then 1 held
    k = edge_n;
    raw_a = 1'b1;
    tick(2);
    raw_a = 1'b0;
    tick(1);
    raw_a = 1'b1;
    qa.push_back('{k + 9, 1, 1});
    tick(2);
    chk("bounce_glitch", gl_a, 1);
    chk("bounce_abort_busy", busy_a, 0);
    tick(6);
    chk("bounce_final_d", d_a, 1);
    chk("bounce_final_glitch", gl_a, 1);

    rst = 1'b1; raw_a = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(3);

    // reset during qualification with cnt == 2
    k = edge_n;
    raw_a = 1'b1;
    tick(4);
    chk("midq_busy", busy_a, 1);
    rst = 1'b1; raw_a = 1'b0;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("midq_busy_after", busy_a, 0);
      chk("midq_d_after", d_a, 0);
    end
    chk("midq_glitches", gl_a, 0);

    // saturating 2-bit glitch counter
    for (int b = 1; b <= 5; b++) begin
      raw_b = 1'b1;
      tick(2);
      raw_b = 1'b0;
      tick(6);
      chk("sat_glitches", gl_b, (b < 3) ? b : 3);
      chk("sat_d", d_b, 0);
    end

    // single-cycle window: accept on first mismatch edge
    k = edge_n;
    raw_c = 1'b1;
    qc.push_back('{k + 3, 1, 0});
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("s1_busy_rise", busy_c, 0);
    end
    k = edge_n;
    raw_c = 1'b0;
    qc.push_back('{k + 3, 0, 0});
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("s1_busy_fall", busy_c, 0);
    end
    chk("s1_final_d", d_c, 0);
    chk("s1_glitches", gl_c, 0);

    tick(2);
    chk("a_queue_drained", qa.size(), 0);
    chk("c_queue_drained", qc.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
